// File: rtl/dzcpu_uop_sequencer.sv
// Microcode sequencer: latches opcodes, looks up flow start indices and walks ROM words,
// issuing one registered uop per cycle until the flow's end-of-flow code.
module dzcpu_uop_sequencer #(
  parameter int unsigned UOP_W  = 13,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [7:0]        iMop,
  input  logic              iMopValid,
  output logic [7:0]        oLutMop,
  input  logic [ADDR_W-1:0] iFlowIdx,
  input  logic [ADDR_W-1:0] iCbFlowIdx,
  output logic [ADDR_W-1:0] oUopAddr,
  input  logic [UOP_W-1:0]  iUop,
  input  logic              iZeroFlag,
  input  logic              iStall,
  output logic              oUopValid,
  output logic [3:0]        oUopOp,
  output logic [4:0]        oUopOperand,
  output logic              oIncPc,
  output logic              oFlagUpdate,
  output logic              oEof,
  output logic              oFetchReq,
  output logic [7:0]        oUopCount,
  output logic              oSeqErr
);

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StCbWait} state_e;

  localparam logic [3:0] OpJcb = 4'hF;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        mop_q, mop_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        opd_q, opd_d;
  logic              inc_q, inc_d;
  logic              fu_q, fu_d;
  logic              eof_q, eof_d;
  logic              fetch_q, fetch_d;

  logic [3:0] flow_code;
  logic [3:0] uop_op;
  logic       word_inc;
  logic       word_fu;
  logic       word_ends;

  assign flow_code = iUop[12:9];
  assign uop_op    = iUop[8:5];

  // Flow-code decode; codes 9-15 fall through as plain op.
  always_comb begin
    word_inc  = 1'b0;
    word_fu   = 1'b0;
    word_ends = 1'b0;
    case (flow_code)
      4'd1: word_inc = 1'b1;
      4'd2: word_ends = 1'b1;
      4'd3: begin
        word_inc  = 1'b1;
        word_ends = 1'b1;
      end
      4'd4: begin
        word_fu   = 1'b1;
        word_ends = 1'b1;
      end
      4'd5: begin
        word_inc  = 1'b1;
        word_fu   = 1'b1;
        word_ends = 1'b1;
      end
      4'd6: begin
        word_inc  = 1'b1;
        word_ends = iZeroFlag;
      end
      4'd7: begin
        word_inc  = 1'b1;
        word_ends = ~iZeroFlag;
      end
      4'd8: word_fu = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mop_d   = mop_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    valid_d = 1'b0;
    op_d    = '0;
    opd_d   = '0;
    inc_d   = 1'b0;
    fu_d    = 1'b0;
    eof_d   = 1'b0;
    fetch_d = 1'b0;
    if (!iStall) begin
      unique case (state_q)
        StFetch: begin
          if (iMopValid) begin
            mop_d   = iMop;
            cnt_d   = '0;
            state_d = StDecode;
          end
        end
        StDecode: begin
          addr_d  = iFlowIdx;
          state_d = StExec;
        end
        StExec: begin
          if (uop_op == OpJcb) begin
            // Prefix escape: address is reloaded from the CB table, so it simply holds here.
            state_d = StCbWait;
          end else begin
            valid_d = 1'b1;
            op_d    = uop_op;
            opd_d   = iUop[4:0];
            inc_d   = word_inc;
            fu_d    = word_fu;
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            if (word_ends) begin
              eof_d   = 1'b1;
              state_d = StFetch;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
              if (addr_q == '1) err_d = 1'b1;
            end
          end
        end
        StCbWait: begin
          if (iMopValid) begin
            mop_d   = iMop;
            addr_d  = iCbFlowIdx;
            state_d = StExec;
          end
        end
      endcase
      fetch_d = (state_d == StFetch) || (state_d == StCbWait);
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= StFetch;
      addr_q  <= '0;
      mop_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= '0;
      opd_q   <= '0;
      inc_q   <= 1'b0;
      fu_q    <= 1'b0;
      eof_q   <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mop_q   <= mop_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      opd_q   <= opd_d;
      inc_q   <= inc_d;
      fu_q    <= fu_d;
      eof_q   <= eof_d;
      fetch_q <= fetch_d;
    end
  end

  assign oLutMop     = mop_q;
  assign oUopAddr    = addr_q;
  assign oUopValid   = valid_q;
  assign oUopOp      = op_q;
  assign oUopOperand = opd_q;
  assign oIncPc      = inc_q;
  assign oFlagUpdate = fu_q;
  assign oEof        = eof_q;
  assign oFetchReq   = fetch_q;
  assign oUopCount   = cnt_q;
  assign oSeqErr     = err_q;

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Bench for dzcpu_uop_sequencer: a small ROM/LUT environment, a flow-walking reference model
// that predicts each instruction's uop list, directed timing checks and random traffic.
module tb_dzcpu_uop_sequencer;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [7:0]  iMop = '0;
  logic        iMopValid = 1'b0;
  logic [7:0]  oLutMop;
  logic [7:0]  iFlowIdx;
  logic [7:0]  iCbFlowIdx;
  logic [7:0]  oUopAddr;
  logic [12:0] iUop;
  logic        iZeroFlag = 1'b0;
  logic        iStall = 1'b0;
  logic        oUopValid;
  logic [3:0]  oUopOp;
  logic [4:0]  oUopOperand;
  logic        oIncPc;
  logic        oFlagUpdate;
  logic        oEof;
  logic        oFetchReq;
  logic [7:0]  oUopCount;
  logic        oSeqErr;

  logic [12:0] rom   [256];
  logic [7:0]  lut   [256];
  logic [7:0]  cblut [256];

  assign iUop       = rom[oUopAddr];
  assign iFlowIdx   = lut[oLutMop];
  assign iCbFlowIdx = cblut[iMop];

  always #5 iClock = ~iClock;

  dzcpu_uop_sequencer #(.UOP_W(13), .ADDR_W(8)) dut (
    .iClock(iClock), .iReset(iReset), .iMop(iMop), .iMopValid(iMopValid),
    .oLutMop(oLutMop), .iFlowIdx(iFlowIdx), .iCbFlowIdx(iCbFlowIdx), .oUopAddr(oUopAddr),
    .iUop(iUop), .iZeroFlag(iZeroFlag), .iStall(iStall), .oUopValid(oUopValid),
    .oUopOp(oUopOp), .oUopOperand(oUopOperand), .oIncPc(oIncPc), .oFlagUpdate(oFlagUpdate),
    .oEof(oEof), .oFetchReq(oFetchReq), .oUopCount(oUopCount), .oSeqErr(oSeqErr)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [4:0] opd;
    logic       inc;
    logic       fu;
    logic       eof;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   ncmp = 0;
  int   nerr = 0;
  bit   done;
  int   last_cnt;
  int   ncb;

  function automatic logic [12:0] mk(input int code, input int op, input int opd);
    logic [3:0] c;
    logic [3:0] o;
    logic [4:0] d;
    c = code[3:0];
    o = op[3:0];
    d = opd[4:0];
    return {c, o, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the flow from its LUT start, following the CB escape, per the flow-code rules.
  task automatic model(input logic [7:0] mop, input logic [7:0] cb, input logic z,
                       output int cbs);
    logic [7:0] a;
    logic [3:0] code;
    logic [3:0] op;
    int n;
    bit ends;
    exp_t e;
    a = lut[mop];
    n = 0;
    cbs = 0;
    for (int guard = 0; guard < 600; guard++) begin
      code = rom[a][12:9];
      op   = rom[a][8:5];
      if (op == 4'hF) begin
        a = cblut[cb];
        cbs++;
      end else begin
        n++;
        ends  = (code >= 2 && code <= 5) || (code == 6 && z) || (code == 7 && !z);
        e.op  = op;
        e.opd = rom[a][4:0];
        e.inc = (code == 1 || code == 3 || code == 5 || code == 6 || code == 7);
        e.fu  = (code == 4 || code == 5 || code == 8);
        e.eof = ends;
        e.cnt = (n > 255) ? 8'hFF : 8'(n);
        exp_q.push_back(e);
        if (ends) break;
        a = a + 8'd1;
      end
    end
  endtask

  // One clock; afterwards compare whatever the DUT issued against the predicted list.
  task automatic cycle();
    logic       st;
    logic       rs;
    logic [7:0] addr_before;
    exp_t       e;
    st = iStall;
    rs = iReset;
    addr_before = oUopAddr;
    @(posedge iClock);
    #1;
    if (!rs) begin
      if (st) begin
        check("stall_valid", oUopValid, 0);
        check("stall_fetchreq", oFetchReq, 0);
        check("stall_addr_hold", oUopAddr, addr_before);
      end
      if (oUopValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_uop", oUopValid, 0);
        end else begin
          e = exp_q.pop_front();
          check("uop_op", oUopOp, e.op);
          check("uop_operand", oUopOperand, e.opd);
          check("uop_incpc", oIncPc, e.inc);
          check("uop_flagupd", oFlagUpdate, e.fu);
          check("uop_eof", oEof, e.eof);
          check("uop_count", oUopCount, e.cnt);
          if (oEof) begin
            done = 1'b1;
            last_cnt = oUopCount;
          end
        end
      end else begin
        check("idle_flags", {oIncPc, oFlagUpdate, oEof}, 0);
      end
    end
  endtask

  task automatic rand_stall(input bit rs);
    iStall = rs ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rs);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      rand_stall(rs);
      if (oFetchReq) begin
        iMop = b;
        iMopValid = 1'b1;
        got = !iStall;
        cycle();
        iMopValid = 1'b0;
      end else begin
        cycle();
      end
    end
    iStall = 1'b0;
    check("send_byte_accepted", got, 1);
  endtask

  task automatic wait_eof(input bit rs);
    for (int i = 0; i < 400 && !done; i++) begin
      rand_stall(rs);
      cycle();
    end
    iStall = 1'b0;
    check("eof_seen", done, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_instr(input logic [7:0] mop, input logic [7:0] cb, input logic z,
                           input bit rs);
    int cbs;
    done = 1'b0;
    iZeroFlag = z;
    model(mop, cb, z, cbs);
    send_byte(mop, rs);
    if (cbs > 0) send_byte(cb, rs);
    wait_eof(rs);
  endtask

  initial begin
    logic [7:0] r;
    int sel;
    for (int i = 0; i < 256; i++) begin
      rom[i]   = mk(2, i % 15, i);
      lut[i]   = 8'd0;
      cblut[i] = 8'd0;
    end
    rom[0]    = mk(3, 1, 0);
    rom[162]  = mk(3, 2, 5);
    rom[1]    = mk(1, 3, 1);
    rom[2]    = mk(1, 3, 2);
    rom[3]    = mk(0, 4, 3);
    rom[4]    = mk(3, 5, 4);
    rom[12]   = mk(0, 6, 1);
    rom[13]   = mk(1, 6, 2);
    rom[14]   = mk(8, 7, 3);
    rom[15]   = mk(0, 15, 0);
    rom[16]   = mk(4, 8, 9);
    rom[17]   = mk(1, 1, 17);
    rom[18]   = mk(0, 2, 18);
    rom[19]   = mk(6, 3, 19);
    rom[20]   = mk(0, 4, 20);
    rom[21]   = mk(1, 5, 21);
    rom[22]   = mk(2, 6, 22);
    rom[30]   = mk(1, 1, 1);
    rom[31]   = mk(1, 2, 2);
    rom[32]   = mk(0, 3, 3);
    rom[33]   = mk(9, 4, 4);
    rom[34]   = mk(7, 5, 5);
    rom[35]   = mk(5, 6, 6);
    rom[254]  = mk(0, 1, 30);
    rom[255]  = mk(8, 2, 31);
    lut[8'h00] = 8'd162;
    lut[8'h31] = 8'd1;
    lut[8'h20] = 8'd17;
    lut[8'hCB] = 8'd12;
    lut[8'hCD] = 8'd30;
    lut[8'hD3] = 8'hFE;
    cblut[8'h7C] = 8'd16;

    // Reset state
    cycle();
    cycle();
    check("rst_addr", oUopAddr, 0);
    check("rst_lutmop", oLutMop, 0);
    check("rst_count", oUopCount, 0);
    check("rst_seqerr", oSeqErr, 0);
    check("rst_outs", {oUopValid, oIncPc, oFlagUpdate, oEof, oFetchReq}, 0);
    iReset = 1'b0;

    // NOP: exact latency of a one-uop flow
    done = 1'b0;
    model(8'h00, 8'h00, 1'b0, ncb);
    send_byte(8'h00, 1'b0);
    cycle();
    check("nop_decode_addr", oUopAddr, 162);
    check("nop_decode_valid", oUopValid, 0);
    cycle();
    check("nop_valid", oUopValid, 1);
    check("nop_eof", oEof, 1);
    check("nop_count", oUopCount, 1);
    cycle();
    check("nop_fetchreq_next", oFetchReq, 1);
    check("nop_done", done, 1);

    // LDSPnn with a 3-cycle stall on word 2
    done = 1'b0;
    model(8'h31, 8'h00, 1'b0, ncb);
    send_byte(8'h31, 1'b0);
    check("ldsp_lutmop", oLutMop, 8'h31);
    cycle();
    cycle();
    check("ldsp_addr_w2", oUopAddr, 2);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("ldsp_stall_addr", oUopAddr, 2);
    end
    iStall = 1'b0;
    cycle();
    check("ldsp_post_stall_cnt", oUopCount, 2);
    check("ldsp_post_stall_valid", oUopValid, 1);
    wait_eof(1'b0);
    check("ldsp_total", last_cnt, 4);

    // JRNZn both ways
    run_instr(8'h20, 8'h00, 1'b1, 1'b0);
    check("jrnz_z1_total", last_cnt, 3);
    run_instr(8'h20, 8'h00, 1'b0, 1'b1);
    check("jrnz_z0_total", last_cnt, 6);

    // CB prefix
    done = 1'b0;
    model(8'hCB, 8'h7C, 1'b0, ncb);
    send_byte(8'hCB, 1'b0);
    for (int i = 0; i < 20 && !oFetchReq; i++) cycle();
    check("cb_wait_req", oFetchReq, 1);
    check("cb_wait_addr", oUopAddr, 15);
    check("cb_wait_cnt", oUopCount, 3);
    send_byte(8'h7C, 1'b0);
    check("cb_lutmop", oLutMop, 8'h7C);
    check("cb_addr", oUopAddr, 16);
    wait_eof(1'b0);
    check("cb_total", last_cnt, 4);

    // Random traffic with random stalls and Z
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 5);
      r = 8'($urandom_range(0, 255));
      if (r == 8'hD3) r = 8'h01;
      case (sel)
        0: run_instr(8'h00, 8'h00, 1'($urandom_range(0, 1)), 1'b1);
        1: run_instr(8'h31, 8'h00, 1'($urandom_range(0, 1)), 1'b1);
        2: run_instr(8'h20, 8'h00, 1'($urandom_range(0, 1)), 1'b1);
        3: run_instr(8'hCB, ($urandom_range(0, 1) == 1) ? 8'h7C : r, 1'b0, 1'b1);
        4: run_instr(8'hCD, 8'h00, 1'($urandom_range(0, 1)), 1'b1);
        default: run_instr(r, r, 1'($urandom_range(0, 1)), 1'b1);
      endcase
    end

    // Reset in the middle of CALLnn
    done = 1'b0;
    iZeroFlag = 1'b0;
    model(8'hCD, 8'h00, 1'b0, ncb);
    send_byte(8'hCD, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    check("call_mid_valid", oUopValid, 1);
    iReset = 1'b1;
    cycle();
    check("midrst_outs", {oUopValid, oUopOp, oUopOperand, oIncPc, oFlagUpdate, oEof, oFetchReq}, 0);
    check("midrst_addr", oUopAddr, 0);
    check("midrst_count", oUopCount, 0);
    check("midrst_lutmop", oLutMop, 0);
    iReset = 1'b0;
    exp_q.delete();
    cycle();
    check("midrst_fetch", oFetchReq, 1);

    // Address wrap inside a flow
    done = 1'b0;
    model(8'hD3, 8'h00, 1'b0, ncb);
    send_byte(8'hD3, 1'b0);
    cycle();
    check("wrap_addr_fe", oUopAddr, 8'hFE);
    cycle();
    check("wrap_addr_ff", oUopAddr, 8'hFF);
    check("wrap_err_pre", oSeqErr, 0);
    cycle();
    check("wrap_addr_00", oUopAddr, 8'h00);
    check("wrap_err_set", oSeqErr, 1);
    wait_eof(1'b0);
    check("wrap_total", last_cnt, 3);
    run_instr(8'h00, 8'h00, 1'b0, 1'b1);
    check("wrap_err_sticky", oSeqErr, 1);
    iReset = 1'b1;
    cycle();
    check("wrap_err_cleared", oSeqErr, 0);
    iReset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
